uart_rx_fifo: RTL

Parametrised UART receiver, successor to the fixed 8N1 serial-input block. Provides:
- an internal oversampling baud-tick generator;
- configurable frame format;
- majority-vote bit sampling with glitch rejection;
- per-byte error flags;
- a small receive FIFO that drives hardware flow control (CTS).

It sits between the external TX line and the serial-to-SPI bridge logic, which drains it through a valid/ready handshake.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_baud_tick.sv | 16 +
 rtl/uart_rx_fifo.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the oversampling UART receiver
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} state_e;
  function automatic int div_calc(longint clk_hz, longint baud, longint os);
    return int'((clk_hz + baud * os / 2) / (baud * os));
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider emitting a one-clk tick every DIV clocks, with sync restart
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(DIV + 1);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with majority-vote sampling, error flags,
// first-word-fall-through receive FIFO and CTS flow control
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 TX_D,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic                 CTS,
  output logic                 busy
);
  localparam int DIV = div_calc(CLK_HZ, BAUD, OVERSAMPLE);
  localparam parity_e PMODE = parity_e'(PARITY);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int HW = $clog2(OVERSAMPLE + 1);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_BITS + 2;
  localparam longint ERR = longint'(DIV) * BAUD * OVERSAMPLE - CLK_HZ;
  if (OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 ||
      PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || (ERR < 0 ? -ERR : ERR) * 50 >= CLK_HZ) begin : g_bad
    $error("uart_rx_fifo: unsupported parameter set");
  end
  logic s1, s2, prev, fall, tick, restart, mid, bit_v, push, ferr_n, perr, ferr;
  logic [1:0] warm, samp;
  logic [SW-1:0] sub;
  logic [HW-1:0] hcnt;
  logic [BW-1:0] bcnt;
  logic [DATA_BITS-1:0] sr;
  state_e state, state_n;
  // prev only trusts samples that really came from the line, so a line held low across reset is not a start edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      warm <= '0;
      prev <= 1'b0;
    end else begin
      s1 <= TX_D;
      s2 <= s1;
      warm <= {warm[0], 1'b1};
      prev <= warm[1] & s2;
    end
  assign fall = prev & ~s2;
  uart_baud_tick #(.DIV(DIV)) u_tick (.clk(clk), .rst_n(rst_n), .restart(restart), .tick(tick));
  assign mid = tick && sub == SW'(OVERSAMPLE / 2 + 1);
  assign bit_v = (samp[0] & samp[1]) | (samp[0] & s2) | (samp[1] & s2);
  assign ferr_n = ferr | ~bit_v;
  assign busy = state != S_IDLE;
  always_comb begin
    state_n = state;
    restart = 1'b0;
    push = 1'b0;
    case (state)
      S_IDLE: if (fall) begin
        restart = 1'b1;
        state_n = S_START;
      end
      S_START: if (mid) state_n = bit_v ? S_IDLE : S_DATA;
      S_DATA: if (mid && bcnt == BW'(DATA_BITS - 1)) state_n = PMODE == PAR_NONE ? S_STOP : S_PARITY;
      S_PARITY: if (mid) state_n = S_STOP;
      S_STOP: if (mid && bcnt == BW'(STOP_BITS - 1)) begin
        push = 1'b1;
        state_n = ferr_n ? S_WAIT_IDLE : S_IDLE;
      end
      S_WAIT_IDLE: if (hcnt == HW'(OVERSAMPLE)) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      sub <= '0;
      samp <= '0;
      bcnt <= '0;
      sr <= '0;
      perr <= 1'b0;
      ferr <= 1'b0;
      hcnt <= '0;
    end else begin
      state <= state_n;
      if (restart) sub <= '0;
      else if (tick) sub <= sub == SW'(OVERSAMPLE - 1) ? '0 : sub + 1'b1;
      if (tick && sub == SW'(OVERSAMPLE / 2 - 1)) samp[0] <= s2;
      if (tick && sub == SW'(OVERSAMPLE / 2)) samp[1] <= s2;
      if (mid) bcnt <= state_n != state ? '0 : bcnt + 1'b1;
      if (mid && state == S_DATA) sr <= {bit_v, sr[DATA_BITS-1:1]};
      if (restart) perr <= 1'b0;
      else if (mid && state == S_PARITY) perr <= ^sr ^ bit_v ^ (PMODE == PAR_ODD);
      if (restart) ferr <= 1'b0;
      else if (mid && state == S_STOP) ferr <= ferr_n;
      hcnt <= (state != S_WAIT_IDLE || !s2) ? '0 : hcnt + HW'(tick);
    end
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic full, pop, wr;
  assign full = cnt == CW'(FIFO_DEPTH);
  assign pop = rx_valid & rx_ready;
  assign wr = push & (~full | pop);
  assign rx_valid = cnt != '0;
  assign {rx_ferr, rx_perr, rx_data} = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      overrun <= 1'b0;
      CTS <= 1'b1;
    end else begin
      if (wr) mem[wp] <= {ferr_n, perr, sr};
      wp <= wp + AW'(wr);
      rp <= rp + AW'(pop);
      cnt <= cnt + CW'(wr) - CW'(pop);
      overrun <= push & full & ~pop;
      CTS <= CW'(FIFO_DEPTH) - cnt >= CW'(2);
    end
endmodule
